// File: rtl/term_pkg.sv
// Shared terminal definitions: ASCII control codes, writer state type and buffer geometry.
package term_pkg;

  localparam logic [7:0] CHR_BS  = 8'h08;
  localparam logic [7:0] CHR_LF  = 8'h0A;
  localparam logic [7:0] CHR_FF  = 8'h0C;
  localparam logic [7:0] CHR_CR  = 8'h0D;
  localparam logic [7:0] CHR_DEL = 8'h7F;

  localparam int unsigned BUF_COL_W = 6;
  localparam int unsigned BUF_ROW_W = 5;

  typedef enum logic [1:0] {
    StClrAll,
    StIdle,
    StClrRow
  } term_state_t;

  // Everything from space upward except DEL is drawn, including the upper half.
  function automatic logic is_printable(logic [7:0] b);
    return (b >= 8'h20) && (b != CHR_DEL);
  endfunction

endpackage

// File: rtl/term_writer.sv
// Serial-terminal front end: turns received bytes into character-buffer writes and cursor moves.
// Optional feature: define TERM_FORMFEED_EN to make 0x0C home the cursor and clear the screen.
module term_writer
  import term_pkg::*;
#(
  parameter int unsigned COLS  = 60,
  parameter int unsigned ROWS  = 17,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [10:0] o_address,
  output logic [7:0]  o_data,
  output logic        o_we,
  output logic [5:0]  o_cur_col,
  output logic [4:0]  o_cur_row
);

  localparam logic [BUF_COL_W-1:0] LastCol = BUF_COL_W'(COLS - 1);
  localparam logic [BUF_ROW_W-1:0] LastRow = BUF_ROW_W'(ROWS - 1);

  term_state_t          state_q, state_d;
  logic [10:0]          cnt_q, cnt_d;
  logic [BUF_COL_W-1:0] col_q, col_d;
  logic [BUF_ROW_W-1:0] row_q, row_d;
  logic                 we_q, we_d;
  logic [10:0]          addr_q, addr_d;
  logic [7:0]           data_q, data_d;
  logic [BUF_ROW_W-1:0] next_row;

  assign next_row = (row_q == LastRow) ? '0 : row_q + 5'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      StClrAll: begin
        // Sweeps the whole 64x32 buffer, off-screen cells included.
        we_d   = 1'b1;
        data_d = BLANK;
        addr_d = cnt_q;
        cnt_d  = cnt_q + 11'd1;
        if (cnt_q == 11'd2047) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      StClrRow: begin
        we_d   = 1'b1;
        data_d = BLANK;
        addr_d = {row_q, cnt_q[5:0]};
        cnt_d  = cnt_q + 11'd1;
        if (cnt_q[5:0] == 6'd63) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      StIdle: begin
        if (i_valid) begin
          if (is_printable(i_data)) begin
            we_d   = 1'b1;
            addr_d = {row_q, col_q};
            data_d = i_data;
            if (col_q == LastCol) begin
              col_d   = '0;
              row_d   = next_row;
              state_d = StClrRow;
            end else begin
              col_d = col_q + 6'd1;
            end
          end else begin
            case (i_data)
              CHR_CR: col_d = '0;
              CHR_LF: begin
                row_d   = next_row;
                state_d = StClrRow;
              end
              CHR_BS: begin
                if (col_q != '0) col_d = col_q - 6'd1;
              end
`ifdef TERM_FORMFEED_EN
              CHR_FF: begin
                col_d   = '0;
                row_d   = '0;
                state_d = StClrAll;
              end
`endif
              default: ;
            endcase
          end
        end
      end
      default: state_d = StClrAll;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StClrAll;
      cnt_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign o_ready   = (state_q == StIdle);
  assign o_we      = we_q;
  assign o_address = addr_q;
  assign o_data    = data_q;
  assign o_cur_col = col_q;
  assign o_cur_row = row_q;

endmodule

// File: tb/tb_term_writer.sv
// Bench for term_writer: byte vectors from a table plus hand sequences; every buffer write is
// checked in order against a queue of expected {address, data} records.
module tb_term_writer;

  logic        clk;
  logic        rst;
  logic [7:0]  i_data;
  logic        i_valid;
  logic        o_ready;
  logic [10:0] o_address;
  logic [7:0]  o_data;
  logic        o_we;
  logic [5:0]  o_cur_col;
  logic [4:0]  o_cur_row;

  term_writer dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_data   (i_data),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .o_address(o_address),
    .o_data   (o_data),
    .o_we     (o_we),
    .o_cur_col(o_cur_col),
    .o_cur_row(o_cur_row)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [18:0] exp_q[$];
  logic sb_off = 1'b1;
  int m_col = 0;
  int m_row = 0;
  int last_wait = 0;

  typedef struct {
    logic [7:0] b;
    int         col;
    int         row;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Write scoreboard.
  always @(negedge clk) begin
    if (!sb_off && o_we === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected none", o_address, o_data);
      end else begin
        logic [18:0] e;
        e = exp_q.pop_front();
        if ({o_address, o_data} !== e) begin
          bad++;
          $display("FAIL write: addr 0x%0h data 0x%0h, expected addr 0x%0h data 0x%0h",
                   o_address, o_data, e[18:8], e[7:0]);
        end
      end
    end
  end

  task automatic push_row_clear(input int row);
    for (int c = 0; c < 64; c++) exp_q.push_back({5'(row), 6'(c), 8'h20});
  endtask

  task automatic push_full_clear();
    for (int a = 0; a < 2048; a++) exp_q.push_back({11'(a), 8'h20});
  endtask

  function automatic int inc_row(input int r);
    return (r == 16) ? 0 : r + 1;
  endfunction

  // Reference behaviour of one accepted byte.
  task automatic model(input logic [7:0] b);
    if (b >= 8'h20 && b != 8'h7F) begin
      exp_q.push_back({5'(m_row), 6'(m_col), b});
      if (m_col == 59) begin
        m_col = 0;
        m_row = inc_row(m_row);
        push_row_clear(m_row);
      end else begin
        m_col++;
      end
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h0A) begin
      m_row = inc_row(m_row);
      push_row_clear(m_row);
    end else if (b == 8'h08) begin
      if (m_col > 0) m_col--;
    end
`ifdef TERM_FORMFEED_EN
    else if (b == 8'h0C) begin
      m_col = 0;
      m_row = 0;
      push_full_clear();
    end
`endif
  endtask

  // Hold the byte valid until accepted; last_wait = cycles spent with o_ready low.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    i_valid = 1'b1;
    i_data  = b;
    while (o_ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    last_wait = n;
    if (o_ready !== 1'b1) begin
      chk("send_timeout", n, 0);
      i_valid = 1'b0;
      return;
    end
    model(b);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic chk_cursor(input string name, input int col, input int row);
    chk({name, "_col"}, int'(o_cur_col), col);
    chk({name, "_row"}, int'(o_cur_row), row);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  task automatic do_reset(input string name);
    int n;
    sb_off = 1'b1;
    @(negedge clk);
    rst     = 1'b1;
    i_valid = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk({name, "_we"}, int'(o_we), 0);
    chk({name, "_addr"}, int'(o_address), 0);
    chk({name, "_data"}, int'(o_data), 0);
    chk({name, "_ready"}, int'(o_ready), 0);
    chk_cursor(name, 0, 0);
    @(negedge clk);
    rst   = 1'b0;
    m_col = 0;
    m_row = 0;
    push_full_clear();
    sb_off = 1'b0;
    n = 0;
    while (o_ready !== 1'b1 && n < 3000) begin
      n++;
      @(negedge clk);
    end
    chk({name, "_ready_low_cycles"}, n, 2048);
    drain();
  endtask

  vec_t vecs[14];

  initial begin
    rst     = 1'b1;
    i_valid = 1'b0;
    i_data  = 8'h00;

    vecs[0]  = '{8'h41, 1, 0};
    vecs[1]  = '{8'h62, 2, 0};
    vecs[2]  = '{8'h08, 1, 0};
    vecs[3]  = '{8'h0D, 0, 0};
    vecs[4]  = '{8'h08, 0, 0};
    vecs[5]  = '{8'h07, 0, 0};
    vecs[6]  = '{8'h7F, 0, 0};
    vecs[7]  = '{8'h80, 1, 0};
    vecs[8]  = '{8'hFF, 2, 0};
    vecs[9]  = '{8'h00, 2, 0};
    vecs[10] = '{8'h1F, 2, 0};
    vecs[11] = '{8'h0A, 2, 1};
    vecs[12] = '{8'h7E, 3, 1};
    vecs[13] = '{8'h0D, 0, 1};

    repeat (3) @(negedge clk);
    do_reset("reset");

    for (int i = 0; i < 14; i++) begin
      send(vecs[i].b);
      chk_cursor($sformatf("vec%0d", i), vecs[i].col, vecs[i].row);
    end
    drain();

    // Fill row 3 exactly: wrap to row 4 and blank 0x100..0x13F.
    send(8'h0A);
    send(8'h0A);
    chk_cursor("to_row3", 0, 3);
    for (int i = 0; i < 60; i++) send(8'h42);
    chk_cursor("row_wrap", 0, 4);
    drain();

    // LF on the last row wraps to row 0 and blanks it.
    for (int i = 0; i < 12; i++) send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h63);
    chk_cursor("at_16_5", 5, 16);
    send(8'h0A);
    chk_cursor("lf_wrap", 5, 0);
    drain();

    send(8'h0D);
    for (int i = 0; i < 7; i++) send(8'h64);
    send(8'h08);
    chk_cursor("bs_col7", 6, 0);

    // Byte offered during a row clear is taken once, on the first ready cycle.
    send(8'h0A);
    send(8'h5A);
    chk("held_wait_cycles", last_wait, 64);
    chk_cursor("held", 7, 1);
    drain();

    send(8'h0D);
    for (int i = 0; i < 4; i++) send(8'h0A);
    for (int i = 0; i < 10; i++) send(8'h65);
    chk_cursor("at_5_10", 10, 5);
    send(8'h0C);
`ifdef TERM_FORMFEED_EN
    chk_cursor("ff", 0, 0);
    drain();
`else
    chk_cursor("ff", 10, 5);
`endif
    drain();

    // Reset in the middle of a row clear restarts the full clear.
    send(8'h0A);
    repeat (30) @(negedge clk);
    do_reset("mid_reset");
    send(8'h41);
    chk_cursor("after_reset", 1, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
